// File: rtl/cpu_core.sv
// cpu_core: multi-cycle core with 18-bit instructions, fetch/store/keyboard handshakes.
// Define CPU_CORE_STEP_EN to add a dbg_step port that gates each fetch.

// Instruction word: [17:14] opcode, [13:10] rd, [9:6] rs1, [5:2] rs2, [5:0] imm6, [9:0] imm10.
// 0-4 ADD/SUB/AND/OR/XOR, 5 ADDI, 6 LI, 7 CMP, 8-A SHL/SHR/SRA #imm, B JAL, C BR cond,
// D JALR, E STB (rs2 in [13:10]), F with imm6==1 RDKBD; anything else under F halts.
module cpu_core_decode #(
    parameter int DATA_W = 18,
    parameter int REG_AW = 4
) (
    input  logic [17:0]       ir_i,
    output logic              is_alu_o,
    output logic              is_shift_o,
    output logic              is_jump_o,
    output logic              is_store_o,
    output logic              is_kbd_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic              use_imm_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [2:0]        alu_op_o,
    output logic [1:0]        sh_op_o,
    output logic [2:0]        cond_o,
    output logic              wr_o
);
    logic [3:0]        opc;
    logic [DATA_W-1:0] imm6_s, imm10_s;

    assign opc     = ir_i[17:14];
    assign imm6_s  = {{(DATA_W-6){ir_i[5]}}, ir_i[5:0]};
    assign imm10_s = {{(DATA_W-10){ir_i[9]}}, ir_i[9:0]};

    always_comb begin
        is_alu_o   = 1'b0;
        is_shift_o = 1'b0;
        is_jump_o  = 1'b0;
        is_store_o = 1'b0;
        is_kbd_o   = 1'b0;
        rd_o       = ir_i[10 +: REG_AW];
        rs1_o      = ir_i[6 +: REG_AW];
        rs2_o      = ir_i[2 +: REG_AW];
        use_imm_o  = 1'b0;
        imm_o      = imm6_s;
        alu_op_o   = 3'd0;
        sh_op_o    = 2'd0;
        cond_o     = 3'd0;
        wr_o       = 1'b0;
        case (opc)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                is_alu_o = 1'b1; wr_o = 1'b1; alu_op_o = opc[2:0];
            end
            4'h5: begin is_alu_o = 1'b1; wr_o = 1'b1; use_imm_o = 1'b1; end
            4'h6: begin
                is_alu_o = 1'b1; wr_o = 1'b1; use_imm_o = 1'b1;
                imm_o = imm10_s; alu_op_o = 3'd5;
            end
            4'h7: begin is_alu_o = 1'b1; alu_op_o = 3'd1; end
            4'h8, 4'h9, 4'hA: begin
                is_shift_o = 1'b1; wr_o = 1'b1; use_imm_o = 1'b1; sh_op_o = opc[1:0];
            end
            4'hB: begin is_jump_o = 1'b1; wr_o = 1'b1; use_imm_o = 1'b1; imm_o = imm10_s; end
            4'hC: begin
                is_jump_o = 1'b1; use_imm_o = 1'b1; imm_o = imm10_s; cond_o = ir_i[13:11];
            end
            4'hD: begin is_jump_o = 1'b1; wr_o = 1'b1; rs2_o = ir_i[6 +: REG_AW]; end
            4'hE: begin is_store_o = 1'b1; use_imm_o = 1'b1; rs2_o = ir_i[10 +: REG_AW]; end
            default: begin
                is_kbd_o = (ir_i[5:0] == 6'h01);
                wr_o     = (ir_i[5:0] == 6'h01);
            end
        endcase
    end
endmodule

// SUB reports borrow in c_o, so CMP a,b sets C when a < b unsigned.
module cpu_core_alu #(
    parameter int DATA_W = 18
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o,
    output logic              z_o,
    output logic              n_o,
    output logic              c_o
);
    logic [DATA_W:0] s;

    always_comb begin
        s   = '0;
        y_o = '0;
        c_o = 1'b0;
        case (op_i)
            3'd0: begin s = {1'b0, a_i} + {1'b0, b_i}; y_o = s[DATA_W-1:0]; c_o = s[DATA_W]; end
            3'd1: begin s = {1'b0, a_i} - {1'b0, b_i}; y_o = s[DATA_W-1:0]; c_o = s[DATA_W]; end
            3'd2: y_o = a_i & b_i;
            3'd3: y_o = a_i | b_i;
            3'd4: y_o = a_i ^ b_i;
            3'd5: y_o = b_i;
            default: y_o = '0;
        endcase
    end

    assign z_o = (y_o == '0);
    assign n_o = y_o[DATA_W-1];
endmodule

module cpu_core_shifter #(
    parameter int DATA_W = 18
) (
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [4:0]        amt_i,
    output logic [DATA_W-1:0] y_o
);
    always_comb begin
        case (op_i)
            2'd0:    y_o = a_i << amt_i;
            2'd1:    y_o = a_i >> amt_i;
            2'd2:    y_o = DATA_W'($signed(a_i) >>> amt_i);
            default: y_o = a_i;
        endcase
    end
endmodule

module cpu_core_jc (
    input  logic [2:0] cond_i,
    input  logic       z_i,
    input  logic       n_i,
    input  logic       c_i,
    output logic       take_o
);
    always_comb begin
        case (cond_i)
            3'd0:    take_o = 1'b1;
            3'd1:    take_o = z_i;
            3'd2:    take_o = ~z_i;
            3'd3:    take_o = n_i;
            3'd4:    take_o = ~n_i;
            3'd5:    take_o = c_i;
            3'd6:    take_o = ~c_i;
            default: take_o = 1'b0;
        endcase
    end
endmodule

module cpu_core #(
    parameter int PC_W        = 11,
    parameter int DATA_W      = 18,
    parameter int REG_AW      = 4,
    parameter int WR_ADDR_W   = 17,
    parameter int WR_DATA_W   = 9,
    parameter int BOOT_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PC_W-1:0]      i_addr,
    output logic                 i_valid,
    input  logic                 i_ready,
    input  logic [17:0]          i_data,
    input  logic [7:0]           kd,
    input  logic                 kv,
    output logic                 kack,
    output logic [WR_ADDR_W-1:0] bus_wraddr,
    output logic [WR_DATA_W-1:0] bus_wrdata,
    output logic                 bus_wrvalid,
    input  logic                 bus_wrready,
`ifdef CPU_CORE_STEP_EN
    input  logic                 dbg_step,
`endif
    output logic                 halted,
    output logic [3:0]           state_o,
    output logic [PC_W-1:0]      pc_o
);
    localparam int NREG = 2**REG_AW;
    localparam int BCW  = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_BOOT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EX_ALU = 4'd3, S_EX_SHIFT = 4'd4,
        S_EX_JUMP = 4'd5, S_EX_READKBD = 4'd6, S_EX_STB = 4'd7, S_HALTED = 4'd8
    } state_t;

    state_t                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [17:0]           ir_q, ir_d;
    logic [BCW-1:0]        boot_q, boot_d;
    logic [2:0]            flags_q, flags_d;   // {c, n, z}
    logic [DATA_W-1:0]     a_q, a_d, b_q, b_d;
    logic [WR_DATA_W-1:0]  s_q, s_d;
    logic [REG_AW-1:0]     rd_q, rd_d;
    logic [2:0]            alu_op_q, alu_op_d, cond_q, cond_d;
    logic [1:0]            sh_op_q, sh_op_d;
    logic                  wr_q, wr_d;
    logic [DATA_W-1:0]     rf_q [NREG];

    logic                  rf_we;
    logic [REG_AW-1:0]     rf_wa;
    logic [DATA_W-1:0]     rf_wd;

    logic                  dec_alu, dec_shift, dec_jump, dec_store, dec_kbd, dec_use_imm, dec_wr;
    logic [REG_AW-1:0]     dec_rd, dec_rs1, dec_rs2;
    logic [DATA_W-1:0]     dec_imm, alu_y, sh_y;
    logic [2:0]            dec_alu_op, dec_cond;
    logic [1:0]            dec_sh_op;
    logic                  alu_z, alu_n, alu_c, jc_take, fetch_go;

    cpu_core_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_dec (
        .ir_i(ir_q), .is_alu_o(dec_alu), .is_shift_o(dec_shift), .is_jump_o(dec_jump),
        .is_store_o(dec_store), .is_kbd_o(dec_kbd), .rd_o(dec_rd), .rs1_o(dec_rs1),
        .rs2_o(dec_rs2), .use_imm_o(dec_use_imm), .imm_o(dec_imm), .alu_op_o(dec_alu_op),
        .sh_op_o(dec_sh_op), .cond_o(dec_cond), .wr_o(dec_wr)
    );

    cpu_core_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i(alu_op_q), .a_i(a_q), .b_i(b_q), .y_o(alu_y), .z_o(alu_z), .n_o(alu_n), .c_o(alu_c)
    );

    cpu_core_shifter #(.DATA_W(DATA_W)) u_sh (
        .op_i(sh_op_q), .a_i(a_q), .amt_i(b_q[4:0]), .y_o(sh_y)
    );

    cpu_core_jc u_jc (
        .cond_i(cond_q), .z_i(flags_q[0]), .n_i(flags_q[1]), .c_i(flags_q[2]), .take_o(jc_take)
    );

`ifdef CPU_CORE_STEP_EN
    // One armed fetch per sampled dbg_step; the transfer disarms it.
    logic step_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else if (state_q == S_FETCH) begin
            if (step_q && i_ready) step_q <= 1'b0;
            else if (dbg_step)     step_q <= 1'b1;
        end
    end
    assign fetch_go = step_q;
`else
    assign fetch_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_BOOT;
            pc_q     <= '0;
            ir_q     <= '0;
            boot_q   <= '0;
            flags_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            rd_q     <= '0;
            alu_op_q <= '0;
            sh_op_q  <= '0;
            cond_q   <= '0;
            wr_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            boot_q   <= boot_d;
            flags_q  <= flags_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            rd_q     <= rd_d;
            alu_op_q <= alu_op_d;
            sh_op_q  <= sh_op_d;
            cond_q   <= cond_d;
            wr_q     <= wr_d;
            if (rf_we) rf_q[rf_wa] <= rf_wd;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        boot_d      = boot_q;
        flags_d     = flags_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        rd_d        = rd_q;
        alu_op_d    = alu_op_q;
        sh_op_d     = sh_op_q;
        cond_d      = cond_q;
        wr_d        = wr_q;
        rf_we       = 1'b0;
        rf_wa       = rd_q;
        rf_wd       = '0;
        i_valid     = 1'b0;
        kack        = 1'b0;
        bus_wrvalid = 1'b0;
        case (state_q)
            S_BOOT: begin
                if (boot_q == BOOT_LAST) state_d = S_FETCH;
                else                     boot_d  = boot_q + 1'b1;
            end
            S_FETCH: begin
                i_valid = fetch_go;
                if (fetch_go && i_ready) begin
                    ir_d    = i_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d      = rf_q[dec_rs1];
                b_d      = dec_use_imm ? dec_imm : rf_q[dec_rs2];
                s_d      = rf_q[dec_rs2][WR_DATA_W-1:0];
                rd_d     = dec_rd;
                alu_op_d = dec_store ? 3'd0 : dec_alu_op;
                sh_op_d  = dec_sh_op;
                cond_d   = dec_cond;
                wr_d     = dec_wr;
                if (dec_alu)        state_d = S_EX_ALU;
                else if (dec_shift) state_d = S_EX_SHIFT;
                else if (dec_jump)  state_d = S_EX_JUMP;
                else if (dec_store) state_d = S_EX_STB;
                else if (dec_kbd)   state_d = S_EX_READKBD;
                else                state_d = S_HALTED;
            end
            S_EX_ALU: begin
                flags_d = {alu_c, alu_n, alu_z};
                rf_we   = wr_q;
                rf_wd   = alu_y;
                state_d = S_FETCH;
            end
            S_EX_SHIFT: begin
                rf_we   = 1'b1;
                rf_wd   = sh_y;
                state_d = S_FETCH;
            end
            S_EX_JUMP: begin
                // pc_q already points past the jump, so it is the link value
                if (jc_take) begin
                    pc_d  = b_q[PC_W-1:0];
                    rf_we = wr_q;
                    rf_wd = DATA_W'(pc_q);
                end
                state_d = S_FETCH;
            end
            S_EX_READKBD: begin
                if (kv) begin
                    kack    = 1'b1;
                    rf_we   = 1'b1;
                    rf_wd   = DATA_W'(kd);
                    state_d = S_FETCH;
                end
            end
            S_EX_STB: begin
                bus_wrvalid = 1'b1;
                if (bus_wrready) state_d = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_HALTED;
        endcase
    end

    assign i_addr     = pc_q;
    assign bus_wraddr = alu_y[WR_ADDR_W-1:0];
    assign bus_wrdata = s_q;
    assign halted     = (state_q == S_HALTED);
    assign state_o    = state_q;
    assign pc_o       = pc_q;
endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: table of instructions observed through store peeks,
// plus hand-written boot, stall, store backpressure, keyboard, wrap, halt and reset sequences.
module tb_cpu_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] i_addr;
    logic        i_valid;
    logic        i_ready = 1'b0;
    logic [17:0] i_data = '0;
    logic [7:0]  kd = '0;
    logic        kv = 1'b0;
    logic        kack;
    logic [16:0] bus_wraddr;
    logic [8:0]  bus_wrdata;
    logic        bus_wrvalid;
    logic        bus_wrready = 1'b0;
    logic        halted;
    logic [3:0]  state_o;
    logic [10:0] pc_o;
`ifdef CPU_CORE_STEP_EN
    logic        dbg_step = 1'b1;
`endif

    cpu_core dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .kd(kd), .kv(kv), .kack(kack),
        .bus_wraddr(bus_wraddr), .bus_wrdata(bus_wrdata),
        .bus_wrvalid(bus_wrvalid), .bus_wrready(bus_wrready),
`ifdef CPU_CORE_STEP_EN
        .dbg_step(dbg_step),
`endif
        .halted(halted), .state_o(state_o), .pc_o(pc_o)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    logic [10:0] model_pc = '0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [17:0] enc_r(input logic [3:0] op, rd, rs1, rs2);
        return {op, rd, rs1, rs2, 2'b00};
    endfunction
    function automatic logic [17:0] enc_i(input logic [3:0] op, rd, rs1, input logic [5:0] imm);
        return {op, rd, rs1, imm};
    endfunction
    function automatic logic [17:0] enc_l(input logic [3:0] op, rd, input logic [9:0] imm);
        return {op, rd, imm};
    endfunction
    function automatic logic [17:0] enc_br(input logic [2:0] cond, input logic [9:0] imm);
        return {4'hC, cond, 1'b0, imm};
    endfunction

    typedef struct {
        string       name;
        logic [17:0] ins;
        logic [3:0]  chk_reg;
        logic [17:0] exp;
        logic        lnk;    // expected register value is the return address
        logic        jmp;    // expected next pc is tgt
        logic [10:0] tgt;
        logic        kbd;
        logic [7:0]  kd;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [17:0] ins, input logic [3:0] r,
                                input logic [17:0] exp, input logic lnk, input logic jmp,
                                input logic [10:0] tgt, input logic kbd, input logic [7:0] k);
        vec_t v;
        v.name = nm; v.ins = ins; v.chk_reg = r; v.exp = exp; v.lnk = lnk;
        v.jmp = jmp; v.tgt = tgt; v.kbd = kbd; v.kd = k;
        return v;
    endfunction

    // Wait for a fetch request, check its address, hand over one instruction.
    task automatic issue(input logic [17:0] ins, input logic [10:0] exp_pc, input string nm);
        int n = 0;
        @(negedge clk);
        while (!i_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!i_valid) begin
            chk({nm, " fetch timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, " i_addr"}, 32'(i_addr), 32'(exp_pc));
            chk({nm, " pc_o"}, 32'(pc_o), 32'(exp_pc));
        end
        i_data  = ins;
        i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
    endtask

    // Expose a register by storing it to [reg+0]; address shows bits 16:0, data bits 8:0.
    task automatic peek(input logic [3:0] r, input logic [17:0] exp, input string nm);
        int n = 0;
        issue(enc_i(4'hE, r, r, 6'h00), model_pc, {nm, " peek"});
        model_pc = model_pc + 1'b1;
        @(negedge clk);
        while (!bus_wrvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus_wrvalid) begin
            chk({nm, " store timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, " value"}, 32'(bus_wraddr), 32'(exp[16:0]));
            chk({nm, " data"}, 32'(bus_wrdata), 32'(exp[8:0]));
        end
        bus_wrready = 1'b1;
        @(posedge clk);
        #1 bus_wrready = 1'b0;
    endtask

    task automatic boot_check(input string nm);
        int n = 0;
        @(negedge clk);
        chk({nm, " reset state"}, 32'(state_o), 32'd0);
        chk({nm, " reset outs"}, {28'd0, i_valid, kack, bus_wrvalid, halted}, 32'd0);
        chk({nm, " reset pc"}, 32'(pc_o), 32'd0);
        rst_n = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!i_valid && n < 30);
        chk({nm, " boot clocks"}, 32'(n), 32'd8);
        chk({nm, " first i_addr"}, 32'(i_addr), 32'd0);
        model_pc = '0;
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        logic [10:0] link;
        logic [16:0] a0;
        logic [8:0]  d0;
        int hi, xf, stall;
        bit stable;

        tbl.push_back(mk("li_pos",   enc_l(4'h6, 4'd1, 10'h123), 4'd1, 18'h00123, 0, 0, 0, 0, 0));
        tbl.push_back(mk("li_neg",   enc_l(4'h6, 4'd2, 10'h3FF), 4'd2, 18'h3FFFF, 0, 0, 0, 0, 0));
        tbl.push_back(mk("add_wrap", enc_r(4'h0, 4'd3, 4'd1, 4'd2), 4'd3, 18'h00122, 0, 0, 0, 0, 0));
        tbl.push_back(mk("sub",      enc_r(4'h1, 4'd4, 4'd1, 4'd3), 4'd4, 18'h00001, 0, 0, 0, 0, 0));
        tbl.push_back(mk("and",      enc_r(4'h2, 4'd5, 4'd1, 4'd3), 4'd5, 18'h00122, 0, 0, 0, 0, 0));
        tbl.push_back(mk("xor",      enc_r(4'h4, 4'd6, 4'd1, 4'd3), 4'd6, 18'h00001, 0, 0, 0, 0, 0));
        tbl.push_back(mk("or",       enc_r(4'h3, 4'd7, 4'd4, 4'd3), 4'd7, 18'h00123, 0, 0, 0, 0, 0));
        tbl.push_back(mk("addi_neg", enc_i(4'h5, 4'd8, 4'd1, 6'h3E), 4'd8, 18'h00121, 0, 0, 0, 0, 0));
        tbl.push_back(mk("shl",      enc_i(4'h8, 4'd9, 4'd1, 6'h04), 4'd9, 18'h01230, 0, 0, 0, 0, 0));
        tbl.push_back(mk("shr",      enc_i(4'h9, 4'd10, 4'd2, 6'h03), 4'd10, 18'h07FFF, 0, 0, 0, 0, 0));
        tbl.push_back(mk("sra",      enc_i(4'hA, 4'd11, 4'd2, 6'h03), 4'd11, 18'h3FFFF, 0, 0, 0, 0, 0));
        tbl.push_back(mk("cmp_nowr", enc_r(4'h7, 4'd1, 4'd1, 4'd1), 4'd1, 18'h00123, 0, 0, 0, 0, 0));
        tbl.push_back(mk("br_z",     enc_br(3'd1, 10'h040), 4'd1, 18'h00123, 0, 1, 11'h040, 0, 0));
        tbl.push_back(mk("br_nz",    enc_br(3'd2, 10'h050), 4'd1, 18'h00123, 0, 0, 0, 0, 0));
        tbl.push_back(mk("cmp_lt",   enc_r(4'h7, 4'd4, 4'd4, 4'd1), 4'd4, 18'h00001, 0, 0, 0, 0, 0));
        tbl.push_back(mk("br_c",     enc_br(3'd5, 10'h060), 4'd4, 18'h00001, 0, 1, 11'h060, 0, 0));
        tbl.push_back(mk("br_nn",    enc_br(3'd4, 10'h070), 4'd4, 18'h00001, 0, 0, 0, 0, 0));
        tbl.push_back(mk("br_n",     enc_br(3'd3, 10'h070), 4'd4, 18'h00001, 0, 1, 11'h070, 0, 0));
        tbl.push_back(mk("br_never", enc_br(3'd7, 10'h010), 4'd4, 18'h00001, 0, 0, 0, 0, 0));
        tbl.push_back(mk("jal",      enc_l(4'hB, 4'd12, 10'h00A), 4'd12, 18'h0, 1, 1, 11'h00A, 0, 0));
        tbl.push_back(mk("jalr_trunc", enc_r(4'hD, 4'd13, 4'd9, 4'd0), 4'd13, 18'h0, 1, 1, 11'h230, 0, 0));
        tbl.push_back(mk("rdkbd",    enc_l(4'hF, 4'd14, 10'h001), 4'd14, 18'h0003C, 0, 0, 0, 1, 8'h3C));

        // Reset, boot delay, first fetch address.
        repeat (3) @(posedge clk);
        boot_check("boot");

        // Fetch held off by i_ready=0: address and pc frozen, no decode.
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (i_addr !== 11'd0 || pc_o !== 11'd0 || state_o !== 4'd1 || !i_valid) stable = 1'b0;
        end
        chk("fetch_stall stable", 32'(stable), 32'd1);

        foreach (tbl[i]) begin
            v = tbl[i];
            kv = v.kbd;
            kd = v.kd;
            issue(v.ins, model_pc, v.name);
            link = model_pc + 1'b1;
            model_pc = v.jmp ? v.tgt : link;
            peek(v.chk_reg, v.lnk ? {7'd0, link} : v.exp, v.name);
            kv = 1'b0;
        end

        // ALU fetch-to-fetch latency.
        issue(enc_r(4'h0, 4'd0, 4'd1, 4'd4), model_pc, "lat");
        model_pc = model_pc + 1'b1;
        @(negedge clk); chk("lat decode", 32'(state_o), 32'd2);
        @(negedge clk); chk("lat ex_alu", 32'(state_o), 32'd3);
        @(negedge clk); chk("lat fetch", {31'd0, i_valid}, 32'd1);
        peek(4'd0, 18'h00124, "lat_add");

        // Jump-and-link from the top of the address space.
        issue(enc_l(4'h6, 4'd15, 10'h3FF), model_pc, "li_top");
        model_pc = model_pc + 1'b1;
        issue(enc_r(4'hD, 4'd0, 4'd15, 4'd0), model_pc, "jalr_top");
        model_pc = 11'h7FF;
        issue(enc_l(4'hB, 4'd12, 10'h005), model_pc, "jal_wrap");
        model_pc = 11'h005;
        peek(4'd12, 18'h0, "jal_wrap_link");

        // Store with bus_wrready low for 3 clocks.
        issue(enc_i(4'hE, 4'd7, 4'd7, 6'h01), model_pc, "stb_bp");
        model_pc = model_pc + 1'b1;
        hi = 0; xf = 0; stall = 0;
        @(negedge clk);
        while (!bus_wrvalid && stall < 20) begin
            @(negedge clk);
            stall++;
        end
        a0 = bus_wraddr;
        d0 = bus_wrdata;
        chk("stb_bp addr", 32'(a0), 32'h124);
        chk("stb_bp data", 32'(d0), 32'h123);
        stable = 1'b1;
        repeat (6) begin
            if (bus_wrvalid) begin
                hi++;
                if (bus_wraddr !== a0 || bus_wrdata !== d0) stable = 1'b0;
            end
            bus_wrready = (hi == 4);
            if (bus_wrvalid && bus_wrready) xf++;
            @(posedge clk);
            #1 bus_wrready = 1'b0;
            @(negedge clk);
        end
        chk("stb_bp valid clocks", 32'(hi), 32'd4);
        chk("stb_bp transfers", 32'(xf), 32'd1);
        chk("stb_bp stable", 32'(stable), 32'd1);
        chk("stb_bp back to fetch", 32'(state_o), 32'd1);

        // Keyboard read stalls until kv.
        issue(enc_l(4'hF, 4'd14, 10'h001), model_pc, "kbd_wait");
        model_pc = model_pc + 1'b1;
        @(negedge clk);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (state_o !== 4'd6 || kack !== 1'b0) stable = 1'b0;
        end
        chk("kbd stall", 32'(stable), 32'd1);
        kd = 8'hA5;
        kv = 1'b1;
        #1 chk("kbd kack pulse", 32'(kack), 32'd1);
        @(posedge clk);
        #1 kv = 1'b0;
        @(negedge clk);
        chk("kbd kack single", 32'(kack), 32'd0);
        chk("kbd to fetch", 32'(state_o), 32'd1);
        peek(4'd14, 18'h000A5, "kbd_a5");

        // Undefined opcode halts and stays halted.
        issue(18'h3C000, model_pc, "halt");
        repeat (6) @(negedge clk);
        chk("halt state", 32'(state_o), 32'd8);
        chk("halt flag", 32'(halted), 32'd1);
        chk("halt no fetch", 32'(i_valid), 32'd0);

        // Reset out of HALTED, then reset in the middle of a store.
        rst_n = 1'b0;
        boot_check("reboot");
        issue(enc_i(4'hE, 4'd3, 4'd3, 6'h05), 11'd0, "stb_rst");
        stall = 0;
        @(negedge clk);
        while (!bus_wrvalid && stall < 20) begin
            @(negedge clk);
            stall++;
        end
        chk("stb_rst regs cleared", 32'(bus_wraddr), 32'h5);
        chk("stb_rst valid before", 32'(bus_wrvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("stb_rst valid drop", 32'(bus_wrvalid), 32'd0);
        chk("stb_rst state", 32'(state_o), 32'd0);
        chk("stb_rst pc", 32'(pc_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
